req_ack_arbiter: RTL
====================

REQ_ACK_ARBITER -- requirements
Module: req_ack_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, SHALL set the number of requesters sharing one req/ack responder (range 2..8).
REQ-002 Parameter MIN_GAP, default 8, SHALL set the minimum number of cycles between successive dut_req pulses (range 2..31).
REQ-003 Parameter TIMEOUT, default 15, SHALL set the number of cycles to wait for dut_ack after dut_req (range 4..31, and at least MIN_GAP).
REQ-004 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 req_i  input  N_REQ  SHALL be the per-requester level request, held high until done_o or err_o for that requester.
REQ-007 done_o  output  N_REQ  SHALL carry a one-hot, single-cycle pulse marking transaction completion.
REQ-008 err_o  output  N_REQ  SHALL carry a one-hot, single-cycle pulse marking a timeout (present only with REQ_ACK_TIMEOUT_EN).
REQ-009 dut_req  output  1  SHALL be the single-cycle request pulse to the shared responder.
REQ-010 dut_ack  input  1  SHALL be the responder acknowledge.
REQ-011 grant_id  output  clog2(N_REQ)  SHALL give the index of the requester owning the current transaction.
REQ-012 busy  output  1  SHALL be high in every state except IDLE.

Function
REQ-013 The FSM SHALL have the states IDLE, ISSUE, WAIT_ACK and GAP.
REQ-014 In IDLE with req_i nonzero, the block SHALL register a round-robin winner into grant_id and enter ISSUE on the next edge.
REQ-015 Round-robin priority SHALL start at the index after the last granted index; after reset the pointer SHALL be 0, so index 0 has top priority.
REQ-016 dut_req SHALL be high for exactly one cycle, the ISSUE cycle (cycle t); the FSM SHALL then enter WAIT_ACK.
REQ-017 dut_ack SHALL be accepted only in WAIT_ACK; dut_ack in IDLE, ISSUE or GAP SHALL be ignored with no output effect.
REQ-018 An ack accepted in cycle a SHALL produce done_o[grant_id] high in cycle a+1 only, and the FSM SHALL enter GAP.
REQ-019 With a nominal responder (ack at t+4), done_o SHALL pulse at t+5.
REQ-020 GAP SHALL hold until the cycle-since-issue counter reaches MIN_GAP; the earliest next dut_req SHALL be at t+MIN_GAP.
REQ-021 A new request present at the end of GAP SHALL go directly to ISSUE, skipping IDLE, so that back-to-back dut_req pulses are exactly MIN_GAP apart.
REQ-022 Deassertion of req_i[grant_id] mid-transaction SHALL NOT abort it; done_o SHALL still pulse.
REQ-023 A requester that keeps req_i high after its done_o SHALL re-enter arbitration at lowest priority.
REQ-024 The cycle-since-issue counter SHALL saturate at 31 and never wrap.
REQ-025 grant_id SHALL remain stable from ISSUE until the cycle the FSM leaves GAP or WAIT_ACK.

Reset
REQ-026 Assertion of rst_n low SHALL immediately force: state IDLE, dut_req 0, done_o 0, err_o 0, busy 0, grant_id 0, RR pointer 0, counters 0, even mid-transaction.
REQ-027 After rst_n rises, the first dut_req SHALL occur no earlier than the second rising edge.

Configuration
REQ-028 Macro REQ_ACK_TIMEOUT_EN SHALL control the timeout watchdog.
REQ-029 With REQ_ACK_TIMEOUT_EN defined, if WAIT_ACK sees no ack through cycle t+TIMEOUT, the block SHALL pulse err_o[grant_id] at t+TIMEOUT+1 and go to IDLE, or to ISSUE if a request is pending.
REQ-030 Without REQ_ACK_TIMEOUT_EN, WAIT_ACK SHALL wait indefinitely, and err_o SHALL be tied to 0.

Verification
REQ-031 req_i=0001, ack at t+4 -> dut_req at cycle 1, done_o=0001 at cycle 6, busy low from cycle 9.
REQ-032 req_i=1111 held, ack at t+4 for each -> grant order 0,1,2,3,0, with dut_req at cycles 1, 9, 17, 25, 33.
REQ-033 Spurious dut_ack in IDLE and in GAP -> no done_o and no state change.
REQ-034 With REQ_ACK_TIMEOUT_EN, req_i=0100 and no ack -> err_o=0100 at t+16, then IDLE; without the macro, busy stays high and no err_o.
REQ-035 rst_n low at t+2 of a transaction -> all outputs 0 in the same cycle; after release, req_i=0010 -> dut_req two edges later with grant_id=1.
REQ-036 req_i[0] dropped at t+1 -> done_o=0001 still pulses at t+5.

Source files
------------

// File: rtl/req_ack_if.sv
// req_ack_if: request/done/error bundle shared by the requesters,
// the arbiter and the single req/ack responder.
interface req_ack_if #(
  parameter int N_REQ = 4
);
  localparam int W = $clog2(N_REQ);

  logic [N_REQ-1:0] req_i;
  logic [N_REQ-1:0] done_o;
  logic [N_REQ-1:0] err_o;
  logic             dut_req;
  logic             dut_ack;
  logic [W-1:0]     grant_id;
  logic             busy;

  modport master (
    input  req_i,
    input  dut_ack,
    output done_o,
    output err_o,
    output dut_req,
    output grant_id,
    output busy
  );

  modport slave (
    output req_i,
    output dut_ack,
    input  done_o,
    input  err_o,
    input  dut_req,
    input  grant_id,
    input  busy
  );
endinterface

// File: rtl/req_ack_arbiter.sv
// req_ack_arbiter: round-robin sharing of one req/ack responder by N_REQ
// requesters; define REQ_ACK_TIMEOUT_EN to enable the ack watchdog.
module req_ack_arbiter #(
  parameter int N_REQ   = 4,
  parameter int MIN_GAP = 8,
  parameter int TIMEOUT = 15
) (
  input logic       clk,
  input logic       rst_n,
  req_ack_if.master bus
);

  localparam int W = $clog2(N_REQ);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  if (N_REQ < 2 || N_REQ > 8 ||
      MIN_GAP < 2 || MIN_GAP > 31 ||
      TIMEOUT < 4 || TIMEOUT > 31 ||
      TIMEOUT < MIN_GAP) begin : g_bad_cfg
    $error("req_ack_arbiter: parameter out of range");
  end

  logic [1:0]       state_q;
  logic [1:0]       state_nx;
  logic [W-1:0]     grant_q;
  logic [W-1:0]     ptr_q;
  logic [W-1:0]     win;
  logic [W-1:0]     ptr_nx;
  logic [W:0]       sum;
  logic             win_vld;
  logic [4:0]       cnt_q;
  logic             armed_q;
  logic [N_REQ-1:0] done_q;
  logic             st_idle;
  logic             st_issue;
  logic             st_wait;
  logic             st_gap;
  logic             ack_ok;
  logic             gap_end;
  logic             tmo;
  logic             go;

  assign st_idle  = (state_q == S_IDLE);
  assign st_issue = (state_q == S_ISSUE);
  assign st_wait  = (state_q == S_WAIT);
  assign st_gap   = (state_q == S_GAP);

  assign ack_ok  = st_wait && bus.dut_ack;
  assign gap_end = st_gap && (cnt_q >= 5'(MIN_GAP - 1));

`ifdef REQ_ACK_TIMEOUT_EN
  assign tmo = st_wait && !bus.dut_ack &&
               (cnt_q >= 5'(TIMEOUT));
`else
  assign tmo = 1'b0;
`endif

  assign go = (state_nx == S_ISSUE);

  // Round-robin search starting at the slot after the last grant.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    sum     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sum = {1'b0, ptr_q} + (W+1)'(i);
      if (sum >= (W+1)'(N_REQ))
        sum = sum - (W+1)'(N_REQ);
      if (!win_vld && bus.req_i[sum[W-1:0]]) begin
        win_vld = 1'b1;
        win     = sum[W-1:0];
      end
    end
    ptr_nx = (win == W'(N_REQ - 1)) ? '0 : win + W'(1);
  end

  // Next-state decode; GAP and timeout may chain straight into ISSUE.
  always_comb begin
    state_nx = state_q;
    unique case (1'b1)
      st_idle:
        if (armed_q && win_vld)
          state_nx = S_ISSUE;
      st_issue:
        state_nx = S_WAIT;
      st_wait:
        if (ack_ok)
          state_nx = S_GAP;
        else if (tmo)
          state_nx = win_vld ? S_ISSUE : S_IDLE;
      st_gap:
        if (gap_end)
          state_nx = win_vld ? S_ISSUE : S_IDLE;
      default:
        state_nx = S_IDLE;
    endcase
  end

  // State register plus a one-edge arming delay after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_nx;
      armed_q <= 1'b1;
    end
  end

  // Cycles since issue; restarts on every issue and saturates at 31.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else if (go)
      cnt_q <= '0;
    else if (cnt_q != 5'd31)
      cnt_q <= cnt_q + 5'd1;
  end

  // Latch the winner and advance the priority pointer on issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q <= '0;
      ptr_q   <= '0;
    end else if (go) begin
      grant_q <= win;
      ptr_q   <= ptr_nx;
    end
  end

  // One-cycle completion pulse for the owner of the accepted ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      done_q <= '0;
    else if (ack_ok)
      done_q <= N_REQ'(1) << grant_q;
    else
      done_q <= '0;
  end

`ifdef REQ_ACK_TIMEOUT_EN
  logic [N_REQ-1:0] err_q;

  // One-cycle timeout pulse for the owner of the stalled transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_q <= '0;
    else if (tmo)
      err_q <= N_REQ'(1) << grant_q;
    else
      err_q <= '0;
  end

  assign bus.err_o = err_q;
`else
  assign bus.err_o = '0;
`endif

  assign bus.done_o   = done_q;
  assign bus.dut_req  = st_issue;
  assign bus.grant_id = grant_q;
  assign bus.busy     = !st_idle;

endmodule
